fadd_sched: RTL and testbench

- Shares one fadd datapath (add/sub, single-precision) between NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on each request port.
- Drives the datapath operand registers and tracks in-flight operations with a tag pipeline of depth LAT.
- Routes results into per-requester result FIFOs that have their own valid/ready drain.
- Sits between the core's FP issue paths and the fadd datapath.

---
 rtl/fadd_sched.sv | 163 ++++++++++++++++
 tb/tb_fadd_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_sched.sv
// fadd_sched: round-robin sharing of one fadd datapath across NREQ ports.
// Optional perf counters are enabled by defining FADD_SCHED_PERF_EN.
module fadd_sched #(
  parameter int NREQ  = 2,
  parameter int LAT   = 1,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_sub,
  input  logic [32*NREQ-1:0] req_x1,
  input  logic [32*NREQ-1:0] req_x2,
  output logic [NREQ-1:0]    resp_valid,
  input  logic [NREQ-1:0]    resp_ready,
  output logic [32*NREQ-1:0] resp_y,
  output logic [31:0]        fadd_x1,
  output logic [31:0]        fadd_x2,
  input  logic [31:0]        fadd_y,
  output logic               busy
`ifdef FADD_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_issued,
  output logic [31:0]        perf_conflict,
  output logic [31:0]        perf_stall
`endif
);

  localparam int TW = (NREQ > 2) ? 2 : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [TW-1:0]   rr;
  logic [LAT-1:0]  tv;
  logic [TW-1:0]   tt  [LAT];
  logic [CW-1:0]   cnt [NREQ];
  logic [PW-1:0]   wp  [NREQ];
  logic [PW-1:0]   rp  [NREQ];
  logic [31:0]     mem [NREQ][DEPTH];
  int              used [NREQ];
  logic [NREQ-1:0] credit;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] pop;
  logic [TW-1:0]   win;
  logic [TW-1:0]   ci;
  logic            hs;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Credit: buffered plus in-flight results must leave room in the FIFO.
  always_comb begin
    credit = '0;
    for (int i = 0; i < NREQ; i++) begin
      used[i] = int'(cnt[i]);
      for (int s = 0; s < LAT; s++)
        if (tv[s] && tt[s] == TW'(i))
          used[i] = used[i] + 1;
      credit[i] = used[i] < DEPTH;
    end
  end

  // Round-robin search from rr upward, first eligible port wins.
  always_comb begin
    grant = '0;
    win   = '0;
    hs    = 1'b0;
    ci    = '0;
    for (int k = 0; k < NREQ; k++) begin
      ci = TW'((int'(rr) + k) % NREQ);
      if (!hs && req_valid[ci] && credit[ci]) begin
        hs        = 1'b1;
        grant[ci] = 1'b1;
        win       = ci;
      end
    end
  end

  assign req_ready = grant;

  // FIFO side: status, push from the last tag stage, pop on drain.
  always_comb begin
    resp_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i]      = cnt[i] != '0;
      push[i]            = tv[LAT-1] && tt[LAT-1] == TW'(i);
      pop[i]             = resp_valid[i] && resp_ready[i];
      resp_y[32*i +: 32] = mem[i][rp[i]];
    end
  end

  assign busy = (|tv) | (|resp_valid);

  // Operand issue, tag pipeline shift, FIFO pointers and counts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr      <= '0;
      fadd_x1 <= '0;
      fadd_x2 <= '0;
      tv      <= '0;
      for (int s = 0; s < LAT; s++)
        tt[s] <= '0;
      for (int i = 0; i < NREQ; i++) begin
        cnt[i] <= '0;
        wp[i]  <= '0;
        rp[i]  <= '0;
      end
    end else begin
      if (hs) begin
        rr      <= (win == TW'(NREQ - 1)) ? '0 : win + 1'b1;
        fadd_x1 <= req_x1[32*int'(win) +: 32];
        fadd_x2 <= req_sub[win]
                 ? {~req_x2[32*int'(win)+31], req_x2[32*int'(win) +: 31]}
                 : req_x2[32*int'(win) +: 32];
      end
      tv[0] <= hs;
      tt[0] <= win;
      for (int s = 1; s < LAT; s++) begin
        tv[s] <= tv[s-1];
        tt[s] <= tt[s-1];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (push[i])
          wp[i] <= nxt(wp[i]);
        if (pop[i])
          rp[i] <= nxt(rp[i]);
        if (push[i] && !pop[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (!push[i] && pop[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // Result storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (push[i])
        mem[i][wp[i]] <= fadd_y;
  end

`ifdef FADD_SCHED_PERF_EN
  // Event counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_issued   <= '0;
      perf_conflict <= '0;
      perf_stall    <= '0;
    end else begin
      if (hs)
        perf_issued <= perf_issued + 32'd1;
      if ($countones(req_valid) > 1)
        perf_conflict <= perf_conflict + 32'd1;
      if (|(req_valid & ~credit))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fadd_sched.sv
// tb_fadd_sched: drives a LAT=1 and a LAT=3 scheduler with shared stimulus
// and checks both against a queue-based model plus literal expectations.
module tb_fadd_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  rv, rsub, rrdy;
  logic [63:0] x1, x2;
  logic [1:0]  rdy1, rdy3, vld1, vld3;
  logic [63:0] y1, y3;
  logic [31:0] fx1_1, fx2_1, fy1;
  logic [31:0] fx1_3, fx2_3, fy3, p0, p1;
  logic        busy1, busy3;
`ifdef FADD_SCHED_PERF_EN
  logic [31:0] pi1, pc1, ps1, pi3, pc3, ps3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fadd_sched #(.NREQ(2), .LAT(1), .DEPTH(2)) dut1 (
    .clk(clk), .rstn(rstn), .req_valid(rv), .req_ready(rdy1),
    .req_sub(rsub), .req_x1(x1), .req_x2(x2), .resp_valid(vld1),
    .resp_ready(rrdy), .resp_y(y1), .fadd_x1(fx1_1), .fadd_x2(fx2_1),
    .fadd_y(fy1), .busy(busy1)
`ifdef FADD_SCHED_PERF_EN
    , .perf_issued(pi1), .perf_conflict(pc1), .perf_stall(ps1)
`endif
  );

  fadd_sched #(.NREQ(2), .LAT(3), .DEPTH(2)) dut3 (
    .clk(clk), .rstn(rstn), .req_valid(rv), .req_ready(rdy3),
    .req_sub(rsub), .req_x1(x1), .req_x2(x2), .resp_valid(vld3),
    .resp_ready(rrdy), .resp_y(y3), .fadd_x1(fx1_3), .fadd_x2(fx2_3),
    .fadd_y(fy3), .busy(busy3)
`ifdef FADD_SCHED_PERF_EN
    , .perf_issued(pi3), .perf_conflict(pc3), .perf_stall(ps3)
`endif
  );

  // Stand-in datapath: exact for the documented pairs, a mixing hash otherwise.
  function automatic logic [31:0] dp(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
    return a + {b[15:0], b[31:16]};
  endfunction

  assign fy1 = dp(fx1_1, fx2_1);
  always @(posedge clk) begin
    p0 <= dp(fx1_3, fx2_3);
    p1 <= p0;
  end
  assign fy3 = p1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Model state, per DUT d: RR pointer, operand regs, in-flight slots, FIFOs.
  int          rr_m  [2];
  logic [31:0] fx1_m [2];
  logic [31:0] fx2_m [2];
  bit          pv_m  [2][3];
  int          pt_m  [2][3];
  logic [31:0] py_m  [2][3];
  logic [31:0] fq    [4][$];

  always @(negedge clk) begin : cmp
    int          lat, w, ii;
    int          cnt [2];
    int          inf [2];
    bit          cr  [2];
    logic [1:0]  g, ev, a_rdy, a_vld;
    logic [63:0] a_y;
    logic        a_busy, eb;
    logic [31:0] a_fx1, a_fx2, nx2;
    for (int d = 0; d < 2; d++) begin
      lat    = (d == 0) ? 1 : 3;
      a_rdy  = (d == 0) ? rdy1  : rdy3;
      a_vld  = (d == 0) ? vld1  : vld3;
      a_y    = (d == 0) ? y1    : y3;
      a_busy = (d == 0) ? busy1 : busy3;
      a_fx1  = (d == 0) ? fx1_1 : fx1_3;
      a_fx2  = (d == 0) ? fx2_1 : fx2_3;
      if (!rstn) begin
        rr_m[d]  = 0;
        fx1_m[d] = '0;
        fx2_m[d] = '0;
        for (int s = 0; s < 3; s++) pv_m[d][s] = 1'b0;
        fq[2*d].delete();
        fq[2*d+1].delete();
        chk($sformatf("d%0d_rst_vld", d), 32'(a_vld), 32'h0);
        chk($sformatf("d%0d_rst_busy", d), 32'(a_busy), 32'h0);
        chk($sformatf("d%0d_rst_fx1", d), a_fx1, 32'h0);
        chk($sformatf("d%0d_rst_fx2", d), a_fx2, 32'h0);
      end else begin
        eb = 1'b0;
        for (int s = 0; s < lat; s++)
          if (pv_m[d][s]) eb = 1'b1;
        for (int r = 0; r < 2; r++) begin
          cnt[r] = fq[2*d+r].size();
          inf[r] = 0;
          for (int s = 0; s < lat; s++)
            if (pv_m[d][s] && pt_m[d][s] == r) inf[r]++;
          cr[r]    = (cnt[r] + inf[r]) < 2;
          ev[r[0]] = cnt[r] > 0;
          if (cnt[r] > 0) eb = 1'b1;
        end
        w = -1;
        g = '0;
        for (int k = 0; k < 2; k++) begin
          ii = (rr_m[d] + k) % 2;
          if (w < 0 && rv[ii[0]] && cr[ii]) w = ii;
        end
        if (w >= 0) g[w[0]] = 1'b1;
        chk($sformatf("d%0d_req_ready", d), 32'(a_rdy), 32'(g));
        chk($sformatf("d%0d_resp_valid", d), 32'(a_vld), 32'(ev));
        chk($sformatf("d%0d_busy", d), 32'(a_busy), 32'(eb));
        chk($sformatf("d%0d_fadd_x1", d), a_fx1, fx1_m[d]);
        chk($sformatf("d%0d_fadd_x2", d), a_fx2, fx2_m[d]);
        for (int r = 0; r < 2; r++)
          if (cnt[r] > 0)
            chk($sformatf("d%0d_resp_y%0d", d, r), a_y[32*r +: 32],
                fq[2*d+r][0]);
        for (int r = 0; r < 2; r++)
          if (cnt[r] > 0 && rrdy[r[0]]) void'(fq[2*d+r].pop_front());
        if (pv_m[d][lat-1])
          fq[2*d+pt_m[d][lat-1]].push_back(py_m[d][lat-1]);
        for (int s = lat - 1; s > 0; s--) begin
          pv_m[d][s] = pv_m[d][s-1];
          pt_m[d][s] = pt_m[d][s-1];
          py_m[d][s] = py_m[d][s-1];
        end
        pv_m[d][0] = (w >= 0);
        if (w >= 0) begin
          nx2 = x2[32*w +: 32];
          if (rsub[w[0]]) nx2[31] = ~nx2[31];
          fx1_m[d]   = x1[32*w +: 32];
          fx2_m[d]   = nx2;
          pt_m[d][0] = w;
          py_m[d][0] = dp(x1[32*w +: 32], nx2);
          rr_m[d]    = (w + 1) % 2;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stim
    int acc;
    rstn = 1'b0;
    rv   = '0;
    rsub = '0;
    rrdy = 2'b11;
    x1   = '0;
    x2   = '0;
    step(3);
    chk("lit_rst_vld", 32'(vld1), 32'h0);
    chk("lit_rst_busy", 32'(busy3), 32'h0);
    rstn = 1'b1;
    step();

    // add on port 0
    rv = 2'b01;
    x1[31:0] = 32'h3F800000;
    x2[31:0] = 32'h40000000;
    #1 chk("lit_add_ready", 32'(rdy1), 32'h1);
    step();
    rv = '0;
    chk("lit_add_fx1", fx1_1, 32'h3F800000);
    chk("lit_add_fx2", fx2_1, 32'h40000000);
    step();
    chk("lit_add_vld1", 32'(vld1), 32'h1);
    chk("lit_add_y1", y1[31:0], 32'h40400000);
    chk("lit_model_n", 32'(fq[0].size()), 32'h1);
    chk("lit_model_y", fq[0][0], 32'h40400000);
    step(2);
    chk("lit_add_vld3", 32'(vld3), 32'h1);
    chk("lit_add_y3", y3[31:0], 32'h40400000);
    step();

    // subtract on port 1
    rv = 2'b10;
    rsub = 2'b10;
    x1[63:32] = 32'h40400000;
    x2[63:32] = 32'h3F800000;
    #1 chk("lit_sub_ready", 32'(rdy1), 32'h2);
    step();
    rv = '0;
    chk("lit_sub_fx2", fx2_1, 32'hBF800000);
    step();
    chk("lit_sub_vld1", 32'(vld1), 32'h2);
    chk("lit_sub_y1", y1[63:32], 32'h40000000);
    step(2);
    chk("lit_sub_vld3", 32'(vld3), 32'h2);
    chk("lit_sub_y3", y3[63:32], 32'h40000000);
    step(3);

    // alternating grants from reset
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rv   = 2'b11;
      rsub = 2'(k);
      x1   = {32'h42000000 + 32'(k), 32'h41000000 + 32'(k)};
      x2   = {32'h44000000 + 32'(3*k), 32'h43000000 + 32'(5*k)};
      #1 chk($sformatf("lit_alt%0d", k), 32'(rdy1), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
    end
    rv = '0;
`ifdef FADD_SCHED_PERF_EN
    chk("lit_perf_issued", pi1, 32'd6);
    chk("lit_perf_conflict_ge5", 32'(pc1 >= 32'd5), 32'h1);
`endif
    step(6);

    // credit backpressure on port 0
    rsub = '0;
    rrdy = 2'b10;
    rv   = 2'b01;
    acc  = 0;
    for (int k = 0; k < 8; k++) begin
      #1 if (rdy3[0]) acc++;
      step();
    end
    chk("lit_credit_accepts", 32'(acc), 32'd2);
    rrdy = 2'b11;
    #1 chk("lit_credit_popcyc", 32'(rdy3[0]), 32'h0);
    step();
    rrdy = 2'b10;
    #1 chk("lit_credit_reopen", 32'(rdy3[0]), 32'h1);
    step();
    #1 chk("lit_credit_closed1", 32'(rdy3[0]), 32'h0);
    step();
    #1 chk("lit_credit_closed2", 32'(rdy3[0]), 32'h0);
    rv   = '0;
    rrdy = 2'b11;
    step(8);

    // reset with work in flight and buffered
    rrdy = 2'b00;
    rv   = 2'b01;
    step();
    rv = '0;
    step(2);
    rv = 2'b10;
    step(2);
    rv = '0;
    chk("lit_pre_busy", 32'(busy3), 32'h1);
    chk("lit_pre_vld", 32'(vld3), 32'h1);
    rstn = 1'b0;
    #1;
    chk("lit_midrst_vld", 32'(vld3), 32'h0);
    chk("lit_midrst_busy", 32'(busy3), 32'h0);
    step();
    rstn = 1'b1;
    rrdy = 2'b11;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("lit_nostale%0d", k), 32'(vld3), 32'h0);
    end
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
